// File: rtl/mem_if.sv
// mem_if: sequencer-to-memory strobes, shared data bus and responder status.
interface mem_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_out;
    logic              MAR_EN;
    logic              MDR_EN_write;
    logic              MDR_EN_read;
    logic              mem_EN;
    logic              mem_RW;
    logic              MDR_out;
    logic              bus_drive;
    logic              rd_valid;
    logic              mem_ack;
    logic              err;

    modport master (
        output bus_in, MAR_EN, MDR_EN_write, MDR_EN_read, mem_EN, mem_RW, MDR_out,
        input  bus_out, bus_drive, rd_valid, mem_ack, err
    );

    modport slave (
        input  bus_in, MAR_EN, MDR_EN_write, MDR_EN_read, mem_EN, mem_RW, MDR_out,
        output bus_out, bus_drive, rd_valid, mem_ack, err
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: MAR/MDR plus synchronous RAM driven by load/store sequencer strobes.
module mem_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input logic clk,
    input logic rst,
    mem_if.slave m
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK, WR_HOLD} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic              err_q;
    logic              rd_en;
    logic              wr_en;
    logic              err_set;

    always_comb begin
        state_n = state;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                rd_en   = m.mem_EN & m.mem_RW;
                wr_en   = m.mem_EN & ~m.mem_RW;
                state_n = !m.mem_EN ? IDLE : m.mem_RW ? RD_WAIT : WR_ACK;
            end
            RD_WAIT: begin
                rd_en   = m.mem_EN & m.mem_RW;
                err_set = m.mem_EN & ~m.mem_RW;
                state_n = (m.mem_EN & m.mem_RW) ? RD_WAIT : IDLE;
            end
            WR_ACK, WR_HOLD: state_n = m.mem_EN ? WR_HOLD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            mar     <= '0;
            mdr     <= '0;
            rd_data <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (m.MAR_EN) mar <= m.bus_in[ADDR_W-1:0];
            mdr <= m.MDR_EN_write ? m.bus_in
                 : (m.MDR_EN_read && state == RD_WAIT) ? rd_data : mdr;
            if (rd_en) rd_data <= ram[mar];
            if (err_set) err_q <= 1'b1;
        end
    end

    // RAM contents survive reset; only the write strobe is suppressed by it.
    always_ff @(posedge clk) begin
        if (rst && wr_en) ram[mar] <= mdr;
    end

    assign m.bus_out   = m.MDR_out ? mdr : '0;
    assign m.bus_drive = m.MDR_out;
    assign m.rd_valid  = state == RD_WAIT;
    assign m.mem_ack   = state == WR_ACK;
    assign m.err       = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vector table plus randomized traffic against a flag-based memory model.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   mchk = 1'b0;

    always #5 clk = ~clk;

    mem_if #(.DATA_W(16)) mi ();
    mem_responder #(.DATA_W(16), .ADDR_W(6)) dut (.clk(clk), .rst(rst), .m(mi));

    typedef struct {
        logic        rs, ma, mw, mr, en, rw, mo;
        logic [15:0] bus;
        logic [15:0] bo;
        logic        rv, ack, er;
    } vec_t;

    // Model: an access is "read pending" after any sampled read, "write busy" from the
    // committed write until mem_EN is seen low; ack marks the edge right after a write.
    logic [15:0] mm [64];
    logic [5:0]  m_mar;
    logic [15:0] m_mdr, m_rdd;
    bit          m_rd_pend, m_busy, m_ack, m_err;

    function automatic vec_t v(bit rs, bit ma, bit mw, bit mr, bit en, bit rw, bit mo,
                               logic [15:0] bus, logic [15:0] bo, bit rv, bit ack, bit er);
        vec_t x;
        x.rs = rs; x.ma = ma; x.mw = mw; x.mr = mr; x.en = en; x.rw = rw; x.mo = mo;
        x.bus = bus; x.bo = bo; x.rv = rv; x.ack = ack; x.er = er;
        return x;
    endfunction

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, a, e);
        end
    endtask

    task automatic model_step(input vec_t x);
        logic [15:0] mdr_new;
        bit          n_rd, n_ack;
        if (!x.rs) begin
            m_mar = '0; m_mdr = '0; m_rdd = '0;
            m_rd_pend = 0; m_busy = 0; m_ack = 0; m_err = 0;
            return;
        end
        mdr_new = x.mw ? x.bus : (x.mr && m_rd_pend) ? m_rdd : m_mdr;
        n_rd = 0;
        n_ack = 0;
        if (m_rd_pend) begin
            if (x.en && x.rw) begin
                m_rdd = mm[m_mar];
                n_rd = 1;
            end else if (x.en) m_err = 1;
        end else if (m_busy) begin
            m_busy = x.en;
        end else if (x.en) begin
            if (x.rw) begin
                m_rdd = mm[m_mar];
                n_rd = 1;
            end else begin
                mm[m_mar] = m_mdr;
                m_busy = 1;
                n_ack = 1;
            end
        end
        if (x.ma) m_mar = x.bus[5:0];
        m_mdr = mdr_new;
        m_rd_pend = n_rd;
        m_ack = n_ack;
    endtask

    task automatic cycle(input vec_t x, input bit tab);
        rst = x.rs;
        mi.MAR_EN = x.ma; mi.MDR_EN_write = x.mw; mi.MDR_EN_read = x.mr;
        mi.mem_EN = x.en; mi.mem_RW = x.rw; mi.MDR_out = x.mo; mi.bus_in = x.bus;
        @(negedge clk);
        if (mchk) begin
            chk("bus_out", mi.bus_out, x.mo ? m_mdr : 16'h0);
            chk("bus_drive", {15'h0, mi.bus_drive}, {15'h0, x.mo});
            chk("rd_valid", {15'h0, mi.rd_valid}, {15'h0, m_rd_pend});
            chk("mem_ack", {15'h0, mi.mem_ack}, {15'h0, m_ack});
            chk("err", {15'h0, mi.err}, {15'h0, m_err});
        end
        if (tab) begin
            chk("tab_bus_out", mi.bus_out, x.bo);
            chk("tab_rd_valid", {15'h0, mi.rd_valid}, {15'h0, x.rv});
            chk("tab_mem_ack", {15'h0, mi.mem_ack}, {15'h0, x.ack});
            chk("tab_err", {15'h0, mi.err}, {15'h0, x.er});
        end
        @(posedge clk);
        model_step(x);
        cyc++;
        #1;
    endtask

    function automatic vec_t rnd(bit allow_rst);
        return v(allow_rst ? ($urandom_range(0, 31) != 0) : 1'b0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'h0, 0, 0, 0);
    endfunction

    vec_t tab[$];

    initial begin
        tab.push_back(v(1,1,0,0,0,0,0,16'h0005, 16'h0000,0,0,0));
        tab.push_back(v(1,0,1,0,0,0,0,16'hBEEF, 16'h0000,0,0,0));
        tab.push_back(v(1,0,0,0,1,0,0,16'h0000, 16'h0000,0,0,0));
        tab.push_back(v(1,0,0,0,0,0,1,16'h0000, 16'hBEEF,0,1,0));
        tab.push_back(v(1,0,0,0,0,0,0,16'h0000, 16'h0000,0,0,0));
        tab.push_back(v(1,1,1,0,0,0,0,16'h0005, 16'h0000,0,0,0));
        tab.push_back(v(1,0,0,0,1,1,0,16'h0000, 16'h0000,0,0,0));
        tab.push_back(v(1,0,0,1,1,1,0,16'h0000, 16'h0000,1,0,0));
        tab.push_back(v(1,0,0,0,0,0,1,16'h0000, 16'hBEEF,1,0,0));
        tab.push_back(v(1,0,0,0,0,0,1,16'h0000, 16'hBEEF,0,0,0));
        tab.push_back(v(1,1,1,0,0,0,0,16'h5547, 16'h0000,0,0,0));
        tab.push_back(v(1,0,0,0,1,0,0,16'h0000, 16'h0000,0,0,0));
        tab.push_back(v(1,0,1,0,1,0,0,16'h1234, 16'h0000,0,1,0));
        tab.push_back(v(1,0,0,0,1,0,0,16'h0000, 16'h0000,0,0,0));
        tab.push_back(v(1,0,0,0,0,0,1,16'h0000, 16'h1234,0,0,0));
        tab.push_back(v(1,0,0,0,1,1,0,16'h0000, 16'h0000,0,0,0));
        tab.push_back(v(1,0,0,1,1,1,0,16'h0000, 16'h0000,1,0,0));
        tab.push_back(v(1,0,0,0,0,0,1,16'h0000, 16'h5547,1,0,0));
        tab.push_back(v(1,0,1,0,1,1,0,16'h0BAD, 16'h0000,0,0,0));
        tab.push_back(v(1,0,0,0,1,0,0,16'h0000, 16'h0000,1,0,0));
        tab.push_back(v(1,0,0,0,0,0,1,16'h0000, 16'h0BAD,0,0,1));
        tab.push_back(v(1,0,0,0,1,1,0,16'h0000, 16'h0000,0,0,1));
        tab.push_back(v(1,0,1,1,1,1,0,16'hA5A5, 16'h0000,1,0,1));
        tab.push_back(v(1,0,0,0,0,0,1,16'h0000, 16'hA5A5,1,0,1));
        tab.push_back(v(1,0,0,0,1,1,0,16'h0000, 16'h0000,0,0,1));
        tab.push_back(v(1,0,0,1,1,1,0,16'h0000, 16'h0000,1,0,1));
        tab.push_back(v(1,0,0,0,0,0,1,16'h0000, 16'h5547,1,0,1));
        tab.push_back(v(1,1,0,0,0,0,0,16'hFFC5, 16'h0000,0,0,1));
        tab.push_back(v(1,0,0,0,1,1,0,16'h0000, 16'h0000,0,0,1));
        tab.push_back(v(0,0,0,0,1,1,0,16'h0000, 16'h0000,1,0,1));
        tab.push_back(v(1,0,0,0,0,0,1,16'h0000, 16'h0000,0,0,0));
        tab.push_back(v(1,1,0,0,0,0,0,16'h0005, 16'h0000,0,0,0));
        tab.push_back(v(1,0,0,0,1,1,0,16'h0000, 16'h0000,0,0,0));
        tab.push_back(v(1,0,0,1,1,1,0,16'h0000, 16'h0000,1,0,0));
        tab.push_back(v(1,0,0,0,0,0,1,16'h0000, 16'hBEEF,1,0,0));
        tab.push_back(v(1,0,0,0,0,0,1,16'h0000, 16'hBEEF,0,0,0));
        // MAR load and read at one edge: the read still uses address 5
        tab.push_back(v(1,1,0,0,1,1,0,16'h0007, 16'h0000,0,0,0));
        tab.push_back(v(1,0,0,1,1,1,0,16'h0000, 16'h0000,1,0,0));
        tab.push_back(v(1,0,0,0,0,0,1,16'h0000, 16'hBEEF,1,0,0));
        tab.push_back(v(1,0,0,0,0,0,0,16'h0000, 16'h0000,0,0,0));

        for (int i = 0; i < 2; i++) cycle(rnd(1'b0), 1'b0);
        mchk = 1'b1;
        cycle(v(1,0,0,0,0,0,1,16'h0000, 16'h0000,0,0,0), 1'b1);

        for (int a = 0; a < 64; a++) begin
            cycle(v(1,1,1,0,0,0,0,16'($urandom) & 16'hFFC0 | 16'(a), 0,0,0,0), 1'b0);
            cycle(v(1,0,0,0,1,0,0,16'h0000, 0,0,0,0), 1'b0);
            cycle(v(1,0,0,0,0,0,0,16'h0000, 0,0,0,0), 1'b0);
        end

        foreach (tab[i]) cycle(tab[i], 1'b1);

        for (int i = 0; i < 800; i++) cycle(rnd(1'b1), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
